ram_lsu: RTL and testbench
==========================

// Module: ram_lsu
// PURPOSE
//   Parametrised multi-cycle load/store unit between the regfile/ALU datapath and single-port sync RAM.
//   Accepts one memory request per valid/ready handshake and forms address = base + offset.
//   Sequences CS/WE/OE across a configurable RAM read latency, then writes load data back to the regfile (W/DA/D).
//   Replaces the hard-wired tribuf bus steering with a state machine; no internal tristates.
// PARAMETERS
//   DATA_WIDTH      64  data/regfile word width; base, offset and store data all use this width
//   ADDR_WIDTH      12  RAM word-address width (word addressed, no byte lanes)
//   REG_ADDR_WIDTH  5   regfile address width
//   RAM_LATENCY     1   cycles CS/OE held before read data is valid; must be >=1 (elaboration error otherwise)
// PORTS
//   clk         in   1               rising-edge clock
//   rst         in   1               asynchronous reset, active-high
//   req_valid   in   1               request present
//   req_ready   out  1               unit can accept a request (high only in IDLE)
//   req_load    in   1               1 = load, 0 = store
//   base        in   DATA_WIDTH      address base (regfile A)
//   offset      in   DATA_WIDTH      address offset (constant K)
//   store_data  in   DATA_WIDTH      store data (regfile B)
//   dest        in   REG_ADDR_WIDTH  load destination register
//   CS          out  1               RAM chip select
//   WE          out  1               RAM write enable
//   OE          out  1               RAM output enable
//   mem_addr    out  ADDR_WIDTH      RAM address
//   mem_wdata   out  DATA_WIDTH      RAM write data
//   mem_rdata   in   DATA_WIDTH      RAM read data
//   W           out  1               regfile write strobe
//   DA          out  REG_ADDR_WIDTH  regfile write address
//   D           out  DATA_WIDTH      regfile write data
//   busy        out  1               state != IDLE
//   addr_err    out  1               one-cycle pulse: request rejected, address out of range
// BEHAVIOUR
// - Clock/reset: single clock domain, clk; reset rst is asynchronous and active-high.
// - Reset: state=IDLE. CS, WE, OE, W, busy, addr_err, mem_addr, mem_wdata, DA and D are all 0. req_ready is 0 while rst is high and 1 from the first cycle after release.
// - Reset mid-operation aborts immediately. CS/OE/WE drop asynchronously and no W pulse is issued.
// - Accept: on the rising edge where req_valid & req_ready, latch req_load, dest, store_data and sum = base+offset (modulo 2^DATA_WIDTH).
// - Range check: if sum[DATA_WIDTH-1:ADDR_WIDTH] != 0, go to ERR. Otherwise mem_addr = sum[ADDR_WIDTH-1:0] and go to ACCESS.
// - States and transitions:
//   IDLE   : req_ready=1; all strobes 0; data outputs 0.
//   ERR    : addr_err=1 for exactly one cycle; no RAM or regfile activity; then IDLE.
//   ACCESS, store : CS=1, WE=1, OE=0, mem_wdata=latched data for exactly one cycle; then IDLE.
//   ACCESS, load  : CS=1, OE=1, WE=0; load down-counter with RAM_LATENCY-1.
//     If RAM_LATENCY==1 go to WB, otherwise go to WAIT.
//   WAIT   : CS=OE=1 and mem_addr held; decrement counter; when counter==1 at the edge, go to WB.
//            Total CS/OE-high cycles = RAM_LATENCY.
//   WB     : CS=OE=0; W=1, DA=latched dest, D=mem_rdata (combinational); then IDLE.
//            W is asserted for any dest value, including 31; zero-register semantics belong to the regfile.
// - mem_addr stays stable for the whole access. Outside ACCESS/WAIT, mem_addr and mem_wdata are 0; outside WB, D and DA are 0.
// - Latency from the accept edge: a store returns req_ready after 2 cycles; a load pulses W in cycle RAM_LATENCY+1 and returns req_ready in cycle RAM_LATENCY+2.
// - No back-to-back: at least one IDLE cycle separates operations. req_valid is ignored while req_ready=0, with no queueing.
// - Request inputs may change freely after the accept edge; only latched copies are used.
// - Counter width: $clog2(RAM_LATENCY+1), with a minimum of 1 bit.
// TESTING
// 1. Reset: hold rst mid-load (RAM_LATENCY=3, during WAIT) -> CS/OE fall asynchronously; no W; req_ready=1 the cycle after release.
// 2. Store: base=0x100, offset=0x10, data=0xDEADBEEF -> one cycle with CS=WE=1, mem_addr=0x110; req_ready back 2 cycles after accept.
// 3. Load, RAM_LATENCY=1: load from 0x110 with dest=7 -> CS/OE high 1 cycle, then W=1, DA=7, D=0xDEADBEEF; idle cycle follows.
// 4. Load, RAM_LATENCY=4 -> CS/OE high exactly 4 cycles, W in cycle 5, req_ready in cycle 6; req_valid held high the whole time is not double-accepted.
// 5. Range error: base=0xFFF, offset=1 (sum 0x1000) -> addr_err one cycle; CS, W and busy-to-RAM activity stay 0; req_ready after 2 cycles.
// 6. Wrap-around: base=all-ones, offset=0x6 (sum wraps to 0x5) -> accepted and accesses mem_addr=0x5; no addr_err.

Source files
------------

// File: rtl/ram_lsu.sv
// ram_lsu -- multi-cycle load/store unit sitting between the regfile/ALU
// datapath and a single-port synchronous RAM.
//
// One request is taken per req_valid/req_ready handshake. The effective
// address is base+offset (wrapping at DATA_WIDTH bits); sums that do not
// fit in ADDR_WIDTH bits are rejected with a one-cycle addr_err pulse.
// Stores drive CS/WE for one cycle. Loads hold CS/OE for RAM_LATENCY cycles,
// then write mem_rdata back to the regfile through W/DA/D.
//
// Ports
//   clk, rst                        clock, asynchronous active-high reset
//   req_valid/req_ready             request handshake (ready only in IDLE)
//   req_load, base, offset,
//   store_data, dest                request payload, latched at accept
//   CS, WE, OE, mem_addr,
//   mem_wdata, mem_rdata            RAM interface
//   W, DA, D                        regfile write-back port
//   busy                            unit not idle
//   addr_err                        one-cycle pulse for an out-of-range request
module ram_lsu #(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 12,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int RAM_LATENCY    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_load,
  input  logic [DATA_WIDTH-1:0]     base,
  input  logic [DATA_WIDTH-1:0]     offset,
  input  logic [DATA_WIDTH-1:0]     store_data,
  input  logic [REG_ADDR_WIDTH-1:0] dest,
  output logic                      CS,
  output logic                      WE,
  output logic                      OE,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic                      W,
  output logic [REG_ADDR_WIDTH-1:0] DA,
  output logic [DATA_WIDTH-1:0]     D,
  output logic                      busy,
  output logic                      addr_err
);

  localparam int CNT_W = (RAM_LATENCY < 2) ? 1 : $clog2(RAM_LATENCY + 1);

  generate
    if (RAM_LATENCY < 1) begin : g_bad_latency
      $error("ram_lsu: RAM_LATENCY must be >= 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERR,
    S_ACCESS,
    S_WAIT,
    S_WB
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      load_q, load_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [REG_ADDR_WIDTH-1:0] dest_q, dest_d;

  logic [DATA_WIDTH-1:0]     sum;
  logic                      in_range;
  logic                      accept;

  assign sum      = base + offset;
  assign in_range = (sum[DATA_WIDTH-1:ADDR_WIDTH] == '0);
  // Gated by rst so the unit never advertises ready while held in reset.
  assign req_ready = (state_q == S_IDLE) & ~rst;
  assign accept    = req_valid & req_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load_d    = load_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    dest_d    = dest_q;
    CS        = 1'b0;
    WE        = 1'b0;
    OE        = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    W         = 1'b0;
    DA        = '0;
    D         = '0;
    busy      = (state_q != S_IDLE);
    addr_err  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          load_d  = req_load;
          dest_d  = dest;
          wdata_d = store_data;
          addr_d  = sum[ADDR_WIDTH-1:0];
          state_d = in_range ? S_ACCESS : S_ERR;
        end
      end
      S_ERR: begin
        addr_err = 1'b1;
        state_d  = S_IDLE;
      end
      S_ACCESS: begin
        CS       = 1'b1;
        mem_addr = addr_q;
        if (load_q) begin
          OE = 1'b1;
          // ACCESS is the first of the RAM_LATENCY read cycles; WAIT covers the rest.
          cnt_d   = CNT_W'(RAM_LATENCY - 1);
          state_d = (RAM_LATENCY == 1) ? S_WB : S_WAIT;
        end else begin
          WE        = 1'b1;
          mem_wdata = wdata_q;
          state_d   = S_IDLE;
        end
      end
      S_WAIT: begin
        CS       = 1'b1;
        OE       = 1'b1;
        mem_addr = addr_q;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        W       = 1'b1;
        DA      = dest_q;
        D       = mem_rdata;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state: asynchronous reset aborts any access immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
    end
  end

  // Request payload: only observed through state-gated outputs, so no reset.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    dest_q  <= dest_d;
  end

endmodule

// File: tb/tb_ram_lsu.sv
// Bench for ram_lsu: three instances (RAM_LATENCY 1, 3, 4) share the request
// payload; each has its own req_valid. Expected outputs come from a
// per-cycle description of each request type plus a word-array RAM model.
module tb_ram_lsu;
  localparam int DW = 64;
  localparam int AW = 12;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    req_valid;
  logic [2:0]    req_ready;
  logic          req_load;
  logic [DW-1:0] base, offset, store_data, mem_rdata;
  logic [RW-1:0] dest;
  logic [2:0]    cs, we, oe, w, busy, aerr;
  logic [AW-1:0] maddr [3];
  logic [DW-1:0] mwd [3];
  logic [DW-1:0] dd [3];
  logic [RW-1:0] da [3];

  logic [DW-1:0] mem_m [0:(1<<AW)-1];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ram_lsu #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_ADDR_WIDTH(RW), .RAM_LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_load(req_load), .base(base), .offset(offset), .store_data(store_data), .dest(dest),
    .CS(cs[0]), .WE(we[0]), .OE(oe[0]), .mem_addr(maddr[0]), .mem_wdata(mwd[0]),
    .mem_rdata(mem_rdata), .W(w[0]), .DA(da[0]), .D(dd[0]), .busy(busy[0]), .addr_err(aerr[0]));

  ram_lsu #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_ADDR_WIDTH(RW), .RAM_LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_load(req_load), .base(base), .offset(offset), .store_data(store_data), .dest(dest),
    .CS(cs[1]), .WE(we[1]), .OE(oe[1]), .mem_addr(maddr[1]), .mem_wdata(mwd[1]),
    .mem_rdata(mem_rdata), .W(w[1]), .DA(da[1]), .D(dd[1]), .busy(busy[1]), .addr_err(aerr[1]));

  ram_lsu #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_ADDR_WIDTH(RW), .RAM_LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_load(req_load), .base(base), .offset(offset), .store_data(store_data), .dest(dest),
    .CS(cs[2]), .WE(we[2]), .OE(oe[2]), .mem_addr(maddr[2]), .mem_wdata(mwd[2]),
    .mem_rdata(mem_rdata), .W(w[2]), .DA(da[2]), .D(dd[2]), .busy(busy[2]), .addr_err(aerr[2]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int lat(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Expected outputs of unit i in cycle k after the accept edge (k=0: before).
  task automatic check_cycle(input int i, input int k, input logic ld, input logic err,
                             input logic [AW-1:0] a, input logic [DW-1:0] sd,
                             input logic [RW-1:0] ds, input logic [DW-1:0] rd);
    logic e_cs, e_we, e_oe, e_w, e_busy, e_err;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd, e_d;
    logic [RW-1:0] e_da;
    int L;
    string p;
    L = lat(i);
    e_cs = 0; e_we = 0; e_oe = 0; e_w = 0; e_busy = 0; e_err = 0;
    e_addr = '0; e_wd = '0; e_d = '0; e_da = '0;
    if (k >= 1) begin
      if (err) begin
        if (k == 1) begin e_err = 1; e_busy = 1; end
      end else if (!ld) begin
        if (k == 1) begin e_cs = 1; e_we = 1; e_addr = a; e_wd = sd; e_busy = 1; end
      end else begin
        if (k <= L) begin e_cs = 1; e_oe = 1; e_addr = a; e_busy = 1; end
        else if (k == L + 1) begin e_w = 1; e_da = ds; e_d = rd; e_busy = 1; end
      end
    end
    p = $sformatf("lat%0d k%0d", L, k);
    chk({p, " CS"},        64'(cs[i]),        64'(e_cs));
    chk({p, " WE"},        64'(we[i]),        64'(e_we));
    chk({p, " OE"},        64'(oe[i]),        64'(e_oe));
    chk({p, " mem_addr"},  64'(maddr[i]),     64'(e_addr));
    chk({p, " mem_wdata"}, mwd[i],            e_wd);
    chk({p, " W"},         64'(w[i]),         64'(e_w));
    chk({p, " DA"},        64'(da[i]),        64'(e_da));
    chk({p, " D"},         dd[i],             e_d);
    chk({p, " busy"},      64'(busy[i]),      64'(e_busy));
    chk({p, " addr_err"},  64'(aerr[i]),      64'(e_err));
    chk({p, " req_ready"}, 64'(req_ready[i]), 64'(!e_busy));
  endtask

  // One request presented to all three units; abort_k>0 asserts rst in that cycle.
  task automatic run_txn(input logic ld, input logic [DW-1:0] b, input logic [DW-1:0] o,
                         input logic [DW-1:0] sd, input logic [RW-1:0] ds, input int abort_k);
    logic [DW-1:0] sum, rd;
    logic err;
    logic [AW-1:0] a;
    int blen;
    sum = b + o;
    err = ((sum >> AW) != 0);
    a   = sum[AW-1:0];
    rd  = mem_m[a];
    @(negedge clk);
    for (int i = 0; i < 3; i++) check_cycle(i, 0, ld, err, a, sd, ds, rd);
    req_load = ld; base = b; offset = o; store_data = sd; dest = ds;
    mem_rdata = rd;
    req_valid = 3'b111;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) check_cycle(i, k, ld, err, a, sd, ds, rd);
      if (k == abort_k) begin
        rst = 1'b1;
        req_valid = 3'b000;
        #1;
        for (int i = 0; i < 3; i++) begin
          chk($sformatf("abort lat%0d CS", lat(i)), 64'(cs[i]), 64'd0);
          chk($sformatf("abort lat%0d OE", lat(i)), 64'(oe[i]), 64'd0);
          chk($sformatf("abort lat%0d WE", lat(i)), 64'(we[i]), 64'd0);
          chk($sformatf("abort lat%0d ready", lat(i)), 64'(req_ready[i]), 64'd0);
        end
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++)
          chk($sformatf("abort lat%0d W", lat(i)), 64'(w[i]), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
          chk($sformatf("release lat%0d ready", lat(i)), 64'(req_ready[i]), 64'd1);
          chk($sformatf("release lat%0d W", lat(i)), 64'(w[i]), 64'd0);
          chk($sformatf("release lat%0d busy", lat(i)), 64'(busy[i]), 64'd0);
        end
        return;
      end
      // Payload may change freely once accepted; valid stays high while each unit is busy.
      base = rnd64(); offset = rnd64(); store_data = rnd64();
      dest = RW'($urandom); req_load = 1'($urandom);
      for (int i = 0; i < 3; i++) begin
        blen = (err || !ld) ? 1 : lat(i) + 1;
        req_valid[i] = (k <= blen);
      end
    end
    if (!ld && !err) mem_m[a] = sd;
  endtask

  initial begin
    logic [DW-1:0] o, s;
    logic [AW-1:0] a;
    int kind;
    for (int j = 0; j < (1 << AW); j++) mem_m[j] = '0;
    rst = 1'b1; req_valid = '0; req_load = 0; base = '0; offset = '0;
    store_data = '0; dest = '0; mem_rdata = 64'h5A5A_5A5A_5A5A_5A5A;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst lat%0d ready", lat(i)), 64'(req_ready[i]), 64'd0);
      chk($sformatf("rst lat%0d CS", lat(i)), 64'(cs[i]), 64'd0);
      chk($sformatf("rst lat%0d D", lat(i)), dd[i], 64'd0);
      chk($sformatf("rst lat%0d busy", lat(i)), 64'(busy[i]), 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk($sformatf("post-rst lat%0d ready", lat(i)), 64'(req_ready[i]), 64'd1);

    run_txn(1'b0, 64'h100, 64'h10, 64'hDEADBEEF, 5'd0, 0);   // store
    run_txn(1'b1, 64'h110, 64'h0, rnd64(), 5'd7, 0);         // load back
    run_txn(1'b1, 64'hFFF, 64'h1, rnd64(), 5'd3, 0);         // out of range
    run_txn(1'b0, '1, 64'h6, 64'h0123_4567_89AB_CDEF, 5'd1, 0); // wrap to 0x5
    run_txn(1'b1, '1, 64'h6, rnd64(), 5'd31, 0);             // wrap load, dest 31
    run_txn(1'b1, 64'h110, 64'h0, rnd64(), 5'd9, 2);         // reset during WAIT

    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 3);
      o = rnd64();
      a = AW'(12'h100 + $urandom_range(0, 7));
      if (kind == 3) begin
        s = rnd64() | (64'h1 << $urandom_range(AW, DW - 1));
        run_txn(1'($urandom), s - o, o, rnd64(), RW'($urandom), 0);
      end else begin
        run_txn(kind != 0, 64'(a) - o, o, rnd64(), RW'($urandom), 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
